// File: rtl/mips_port_pkg.sv
// Shared types and constants for the MIPS input-port producer.
// Build option: MIPS_PORT_DBNC_BYPASS_EN (see mips_btn_debounce).
package mips_port_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STAGED   = 2'd1,
    COMMIT   = 2'd2,
    WAIT_REL = 2'd3
  } port_state_e;

  localparam int unsigned STAGED_LO        = 0;
  localparam int unsigned STAGED_HI        = 1;
  localparam int unsigned DBNC_CYCLES_DFLT = 500000;
  localparam int unsigned CNT_W_DFLT       = 20;

endpackage

// File: rtl/mips_btn_debounce.sv
// Two-flop synchronizer, level debouncer and rising-edge press pulse for one button.
// MIPS_PORT_DBNC_BYPASS_EN removes the debounce counter (level follows the synchronizer).
module mips_btn_debounce
  import mips_port_pkg::*;
#(
  parameter int unsigned DBNC_CYCLES = DBNC_CYCLES_DFLT,
  parameter int unsigned CNT_W       = CNT_W_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], raw};
  end

`ifdef MIPS_PORT_DBNC_BYPASS_EN

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      level <= sync[1];
      press <= sync[1] & ~level;
    end
  end

`else

  logic [CNT_W-1:0] cnt;

  // Count while the synchronized level disagrees; accept it after DBNC_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DBNC_CYCLES)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`endif

endmodule

// File: rtl/mips_input_port_ctrl.sv
// Builds a 32-bit word from two switch captures and commits it to the MIPS input port.
// Build option: MIPS_PORT_DBNC_BYPASS_EN skips button debouncing (fast simulation).
module mips_input_port_ctrl
  import mips_port_pkg::*;
#(
  parameter int unsigned SW_WIDTH    = 16,
  parameter int unsigned DBNC_CYCLES = DBNC_CYCLES_DFLT,
  parameter int unsigned CNT_W       = CNT_W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_WIDTH-1:0]   sw_raw,
  input  logic                  sel_raw,
  input  logic                  btn_lo_raw,
  input  logic                  btn_hi_raw,
  input  logic                  btn_go_raw,
  output logic [2*SW_WIDTH-1:0] user_input,
  output logic                  port_sel,
  output logic                  port_en,
  output logic [1:0]            staged,
  output logic                  busy
);

  localparam int unsigned WORD_W = 2 * SW_WIDTH;

  logic [SW_WIDTH-1:0] sw_meta, sw_sync;
  logic                sel_meta, sel_sync;
  logic                lo_press, hi_press, go_press, go_level;
  logic                lo_level_unused, hi_level_unused;
  logic [WORD_W-1:0]   staging, staging_c;
  logic [1:0]          staged_c;
  port_state_e         state;

  // Switches are quasi-static: synchronize only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
    end else begin
      sw_meta  <= sw_raw;
      sw_sync  <= sw_meta;
      sel_meta <= sel_raw;
      sel_sync <= sel_meta;
    end
  end

  mips_btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES), .CNT_W(CNT_W)) u_dbnc_lo (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_lo_raw),
    .level (lo_level_unused),
    .press (lo_press)
  );

  mips_btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES), .CNT_W(CNT_W)) u_dbnc_hi (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_hi_raw),
    .level (hi_level_unused),
    .press (hi_press)
  );

  mips_btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES), .CNT_W(CNT_W)) u_dbnc_go (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_go_raw),
    .level (go_level),
    .press (go_press)
  );

  // Staging after this cycle's lo/hi captures; a same-cycle go commits this value.
  always_comb begin
    staging_c = staging;
    staged_c  = staged;
    if (lo_press) begin
      staging_c[SW_WIDTH-1:0] = sw_sync;
      staged_c[STAGED_LO]     = 1'b1;
    end
    if (hi_press) begin
      staging_c[WORD_W-1:SW_WIDTH] = sw_sync;
      staged_c[STAGED_HI]          = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      staging    <= '0;
      staged     <= 2'b00;
      user_input <= '0;
      port_sel   <= 1'b0;
      port_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      port_en <= 1'b0;
      staging <= staging_c;
      staged  <= staged_c;
      case (state)
        IDLE, STAGED: begin
          if (go_press) begin
            state      <= COMMIT;
            busy       <= 1'b1;
            port_en    <= 1'b1;
            user_input <= staging_c;
            port_sel   <= sel_sync;
          end else if (lo_press || hi_press) begin
            state <= STAGED;
            busy  <= 1'b1;
          end
        end
        COMMIT: begin
          // Clear wins over a capture landing in this cycle; the data half still latches.
          staged <= 2'b00;
          state  <= WAIT_REL;
          busy   <= 1'b1;
        end
        WAIT_REL: begin
          if (!go_level) begin
            if (staged_c != 2'b00) begin
              state <= STAGED;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_input_port_ctrl.sv
// Scoreboard bench for mips_input_port_ctrl with DBNC_CYCLES=8 (or bypass build).
module tb_mips_input_port_ctrl;

  localparam int unsigned DBNC = 8;
`ifdef MIPS_PORT_DBNC_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = DBNC;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic        sel_raw = 1'b0;
  logic        btn_lo_raw = 1'b0;
  logic        btn_hi_raw = 1'b0;
  logic        btn_go_raw = 1'b0;
  logic [31:0] user_input;
  logic        port_sel;
  logic        port_en;
  logic [1:0]  staged;
  logic        busy;

  mips_input_port_ctrl #(.SW_WIDTH(16), .DBNC_CYCLES(DBNC), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sel_raw    (sel_raw),
    .btn_lo_raw (btn_lo_raw),
    .btn_hi_raw (btn_hi_raw),
    .btn_go_raw (btn_go_raw),
    .user_input (user_input),
    .port_sel   (port_sel),
    .port_en    (port_en),
    .staged     (staged),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        sel;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_stage = '0;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_commits = 0;
  int          n_pushed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Raise the selected buttons; first sampled at edge n. Model and scoreboard update here.
  task automatic rise(input logic lo, input logic hi, input logic go, output int n);
    @(negedge clk);
    n = cyc + 1;
    if (lo) begin btn_lo_raw = 1'b1; model_stage[15:0]  = sw_raw; end
    if (hi) begin btn_hi_raw = 1'b1; model_stage[31:16] = sw_raw; end
    if (go) begin
      btn_go_raw = 1'b1;
      exp_q.push_back('{data: model_stage, sel: sel_raw, cyc: n + 3 + LAT});
      n_pushed++;
    end
  endtask

  task automatic fall(input logic lo, input logic hi, input logic go);
    @(negedge clk);
    if (lo) btn_lo_raw = 1'b0;
    if (hi) btn_hi_raw = 1'b0;
    if (go) btn_go_raw = 1'b0;
  endtask

  task automatic press(input logic lo, input logic hi, input logic go);
    int n;
    rise(lo, hi, go, n);
    wait_neg(LAT + 8);
    fall(lo, hi, go);
    wait_neg(LAT + 8);
  endtask

  // Commit monitor: every port_en pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && port_en) begin
      n_commits++;
      if (exp_q.size() == 0) begin
        check("unexpected_port_en", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("user_input", user_input, e.data);
        check("port_sel", 32'(port_sel), 32'(e.sel));
        check("commit_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    wait_neg(3);
    check("rst_user_input", user_input, 32'h0);
    check("rst_port_sel", 32'(port_sel), 32'd0);
    check("rst_port_en", 32'(port_en), 32'd0);
    check("rst_staged", 32'(staged), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_neg(4);

    // Two-half build and commit
    sw_raw = 16'h1234;
    press(1'b1, 1'b0, 1'b0);
    check("t1_staged_lo", 32'(staged), 32'd1);
    check("t1_busy_staged", 32'(busy), 32'd1);
    sw_raw = 16'hABCD;
    press(1'b0, 1'b1, 1'b0);
    check("t1_staged_both", 32'(staged), 32'd3);
    sel_raw = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    check("t1_staged_clear", 32'(staged), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);

`ifndef MIPS_PORT_DBNC_BYPASS_EN
    // Bouncing go: short pulses rejected, single commit after the stable rise
    sel_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); btn_go_raw = 1'b1;
      wait_neg(3);    btn_go_raw = 1'b0;
      wait_neg(3);
    end
    check("t2_no_early_commit", 32'(exp_q.size()), 32'd0);
    rise(1'b0, 1'b0, 1'b1, n);
    wait_neg(20);
    fall(1'b0, 1'b0, 1'b1);
    wait_neg(LAT + 8);
    check("t2_busy_idle", 32'(busy), 32'd0);
`endif

    // Simultaneous lo and hi capture
    sel_raw = 1'b0;
    sw_raw  = 16'h00FF;
    press(1'b1, 1'b1, 1'b0);
    check("t3_staged_both", 32'(staged), 32'd3);
    press(1'b0, 1'b0, 1'b1);

    // hi and go on the same edge: commit sees the fresh half
    sw_raw = 16'h7777;
    press(1'b0, 1'b1, 1'b1);
    check("t3b_staged_clear", 32'(staged), 32'd0);
    check("t3b_busy_idle", 32'(busy), 32'd0);

    // Reset while staged, go held through reset
    sw_raw = 16'h5555;
    press(1'b1, 1'b0, 1'b0);
    check("t4_staged_lo", 32'(staged), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    btn_go_raw = 1'b1;
    wait_neg(3);
    check("t4_rst_user_input", user_input, 32'h0);
    check("t4_rst_staged", 32'(staged), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_port_en", 32'(port_en), 32'd0);
    rst = 1'b0;
    model_stage = '0;
    exp_q.push_back('{data: 32'h0, sel: sel_raw, cyc: cyc + 1 + 3 + LAT});
    n_pushed++;
    wait_neg(LAT + 8);

    // Capture while waiting for go release: exact latency and flag set
    sw_raw = 16'h0F0F;
    rise(1'b1, 1'b0, 1'b0, n);
    wait_neg(LAT + 3);
    check("t6_staged_before", 32'(staged), 32'd0);
    wait_neg(1);
    check("t6_staged_at", 32'(staged), 32'd1);
    check("t5_busy_wait_rel", 32'(busy), 32'd1);
    fall(1'b1, 1'b0, 1'b0);
    wait_neg(LAT + 8);
    check("t5_busy_held", 32'(busy), 32'd1);
    fall(1'b0, 1'b0, 1'b1);
    wait_neg(LAT + 8);
    check("t5_busy_staged", 32'(busy), 32'd1);
    check("t5_staged_kept", 32'(staged), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("t5_staged_clear", 32'(staged), 32'd0);
    check("t5_busy_idle", 32'(busy), 32'd0);

    wait_neg(5);
    check("pending_commits", 32'(exp_q.size()), 32'd0);
    check("commit_count", 32'(n_commits), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
